bit_adder_cell: RTL and testbench



---
 rtl/bit_adder_pkg.sv | 22 ++
 rtl/bit_adder_fa_cell.sv | 16 +
 rtl/bit_adder_cell.sv | 66 ++++++
 tb/tb_bit_adder_cell.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bit_adder_pkg.sv
// rtl/bit_adder_pkg.sv - shared width limits and packed result type for bit_adder_cell
package bit_adder_pkg;

  localparam int BIT_ADDER_DEFAULT_WIDTH = 1;
  localparam int BIT_ADDER_MAX_WIDTH     = 64;

  // Packed {cout, s} for the widest legal cell; narrower callers use the low WIDTH+1 bits.
  typedef logic [BIT_ADDER_MAX_WIDTH:0] bit_adder_result_t;

  // Packs a carry-out and sum into the shared result layout.
  function automatic bit_adder_result_t bit_adder_pack(
    input logic                           cout,
    input logic [BIT_ADDER_MAX_WIDTH-1:0] s,
    input int                             width
  );
    bit_adder_result_t r;
    r = bit_adder_result_t'(s);
    r[width] = cout;
    return r;
  endfunction

endpackage

// File: rtl/bit_adder_fa_cell.sv
// rtl/bit_adder_fa_cell.sv - one-bit combinational full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/bit_adder_cell.sv
// rtl/bit_adder_cell.sv - ripple-carry adder cell; BIT_ADDER_OUTREG_EN selects registered outputs
module bit_adder_cell
  import bit_adder_pkg::*;
#(
  parameter int WIDTH = BIT_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = cin;

  // Plain ripple chain: the carry walks through every cell, no lookahead.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum_c[i]),
      .cout (carry[i+1])
    );
  end

`ifdef BIT_ADDER_OUTREG_EN

  // Output register: reset clears everything, an idle cycle holds the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_c;
        cout <= carry[WIDTH];
      end
    end
  end

`else

  // No flops in this build, so the clock only feeds a sink.
  logic unused_clk;
  assign unused_clk = clk;

  // Zero-latency datapath; reset only masks the valid flag.
  always_comb begin
    s         = sum_c;
    cout      = carry[WIDTH];
    out_valid = in_valid & ~rst;
  end

`endif

endmodule

// File: tb/tb_bit_adder_cell.sv
// tb/tb_bit_adder_cell.sv - self-checking bench for bit_adder_cell in either output mode
module tb_bit_adder_cell;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        cin;
  logic [0:0]  a1, b1, s1;
  logic [3:0]  a4, b4, s4;
  logic [63:0] a64, b64, s64;
  logic        cout1, cout4, cout64;
  logic        ov1, ov4, ov64;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bit_adder_cell #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin),
    .s(s1), .cout(cout1), .out_valid(ov1)
  );

  bit_adder_cell #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin),
    .s(s4), .cout(cout4), .out_valid(ov4)
  );

  bit_adder_cell #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a64), .b(b64), .cin(cin),
    .s(s64), .cout(cout64), .out_valid(ov64)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       sub;
    logic [3:0] s;
    logic       cout;
  } vec_t;

  // Reference: unsigned sum at full precision, no truncation.
  function automatic logic [64:0] ref_sum(input logic [63:0] x, input logic [63:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + 65'(ci);
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: the registered build samples here; the combinational build just holds.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  `ifdef BIT_ADDER_OUTREG_EN
    localparam bit REG_MODE = 1'b1;
  `else
    localparam bit REG_MODE = 1'b0;
  `endif

  vec_t        v1 [8];
  vec_t        v4 [4];
  logic [64:0] e1, e4, e64;
  logic [64:0] h1, h4, h64;
  logic [3:0]  prev_s4;
  logic        prev_c4;

  initial begin
    // Full-adder truth table, WIDTH=1.
    v1[0] = '{a:4'd0, b:4'd0, cin:1'b0, sub:1'b0, s:4'd0, cout:1'b0};
    v1[1] = '{a:4'd0, b:4'd0, cin:1'b1, sub:1'b0, s:4'd1, cout:1'b0};
    v1[2] = '{a:4'd0, b:4'd1, cin:1'b0, sub:1'b0, s:4'd1, cout:1'b0};
    v1[3] = '{a:4'd0, b:4'd1, cin:1'b1, sub:1'b0, s:4'd0, cout:1'b1};
    v1[4] = '{a:4'd1, b:4'd0, cin:1'b0, sub:1'b0, s:4'd1, cout:1'b0};
    v1[5] = '{a:4'd1, b:4'd0, cin:1'b1, sub:1'b0, s:4'd0, cout:1'b1};
    v1[6] = '{a:4'd1, b:4'd1, cin:1'b0, sub:1'b0, s:4'd0, cout:1'b1};
    v1[7] = '{a:4'd1, b:4'd1, cin:1'b1, sub:1'b0, s:4'd1, cout:1'b1};
    // 4-bit add/subtract; sub entries get b inverted by the bench.
    v4[0] = '{a:4'b1011, b:4'b1001, cin:1'b1, sub:1'b1, s:4'b0010, cout:1'b1};
    v4[1] = '{a:4'b0011, b:4'b0101, cin:1'b1, sub:1'b1, s:4'b1110, cout:1'b0};
    v4[2] = '{a:4'b1111, b:4'b0001, cin:1'b0, sub:1'b0, s:4'b0000, cout:1'b1};
    v4[3] = '{a:4'b0101, b:4'b0011, cin:1'b1, sub:1'b0, s:4'b1001, cout:1'b0};

    rst = 1'b1; in_valid = 1'b1; cin = 1'b1;
    a1 = 1'b1; b1 = 1'b1; a4 = 4'd7; b4 = 4'd9; a64 = 64'd5; b64 = 64'd6;

    // Reset state, with an operation presented during reset.
    step();
    step();
    chk("reset_ov4", 65'(ov4), 65'd0);
    chk("reset_ov64", 65'(ov64), 65'd0);
    if (REG_MODE) chk("reset_res4", {60'd0, cout4, s4}, 65'd0);
    else          chk("reset_res4", {60'd0, cout4, s4}, 65'h11);

    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a1 = v1[i].a[0]; b1 = v1[i].b[0]; cin = v1[i].cin; in_valid = 1'b1;
      step();
      chk($sformatf("fa1_%0d", i), {63'd0, cout1, s1}, {63'd0, v1[i].cout, v1[i].s[0]});
      chk($sformatf("fa1_ov_%0d", i), 65'(ov1), 65'd1);
    end

    for (int i = 0; i < 4; i++) begin
      a4 = v4[i].a; b4 = v4[i].sub ? ~v4[i].b : v4[i].b; cin = v4[i].cin; in_valid = 1'b1;
      step();
      chk($sformatf("w4_%0d", i), {60'd0, cout4, s4}, {60'd0, v4[i].cout, v4[i].s});
    end

    // Reset mid-stream: op at cycle 2 is dropped, cycle 3 comes through.
    a4 = 4'd3; b4 = 4'd4; cin = 1'b0; step();
    chk("mid_op0", {60'd0, cout4, s4}, 65'd7);
    a4 = 4'd9; b4 = 4'd9; cin = 1'b1; step();
    chk("mid_op1", {60'd0, cout4, s4}, 65'd19);
    a4 = 4'd15; b4 = 4'd15; cin = 1'b1; rst = 1'b1; step();
    chk("mid_rst_ov", 65'(ov4), 65'd0);
    if (REG_MODE) chk("mid_rst_res", {60'd0, cout4, s4}, 65'd0);
    else          chk("mid_rst_res", {60'd0, cout4, s4}, 65'd31);
    rst = 1'b0; a4 = 4'd6; b4 = 4'd5; cin = 1'b0; step();
    chk("mid_op3", {60'd0, cout4, s4}, 65'd11);
    chk("mid_op3_ov", 65'(ov4), 65'd1);

    // Valid gating 1,0,1 with changing operands.
    a4 = 4'd2; b4 = 4'd3; cin = 1'b0; in_valid = 1'b1; step();
    chk("gate_a_ov", 65'(ov4), 65'd1);
    chk("gate_a", {60'd0, cout4, s4}, 65'd5);
    a4 = 4'd8; b4 = 4'd8; in_valid = 1'b0; step();
    chk("gate_b_ov", 65'(ov4), 65'd0);
    if (REG_MODE) chk("gate_b_hold", {60'd0, cout4, s4}, 65'd5);
    else          chk("gate_b_hold", {60'd0, cout4, s4}, 65'd16);
    a4 = 4'd1; b4 = 4'd1; cin = 1'b1; in_valid = 1'b1; step();
    chk("gate_c_ov", 65'(ov4), 65'd1);
    chk("gate_c", {60'd0, cout4, s4}, 65'd3);

    // Combinational build: results and valid appear without a clock edge.
    if (!REG_MODE) begin
      a1 = 1'b1; b1 = 1'b1; cin = 1'b0; in_valid = 1'b1; rst = 1'b0;
      #1;
      chk("comb_same_cycle", {63'd0, cout1, s1}, 65'd2);
      chk("comb_ov", 65'(ov1), 65'd1);
      rst = 1'b1;
      #1;
      chk("comb_rst_ov", 65'(ov1), 65'd0);
      rst = 1'b0;
      #1;
    end

    // Randomized traffic on all widths against the full-precision model.
    h1 = '0; h4 = '0; h64 = '0;
    for (int i = 0; i < 60; i++) begin
      in_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      a1 = 1'($urandom); b1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      if (i % 7 == 3) begin a64 = '1; b64 = 64'd0; cin = 1'b1; end
      e1 = ref_sum(64'(a1), 64'(b1), cin);
      e4 = ref_sum(64'(a4), 64'(b4), cin);
      e64 = ref_sum(a64, b64, cin);
      if (in_valid || !REG_MODE) begin h1 = e1; h4 = e4; h64 = e64; end
      step();
      chk($sformatf("rnd1_%0d", i), {63'd0, cout1, s1}, h1);
      chk($sformatf("rnd4_%0d", i), {60'd0, cout4, s4}, h4);
      chk($sformatf("rnd64_%0d", i), {cout64, s64}, h64);
      chk($sformatf("rnd_ov_%0d", i), 65'(ov64), 65'(in_valid));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
